// File: rtl/seq_mult_shift_add.sv
// seq_mult_shift_add: sequential shift-and-add unsigned multiplier.
// WIDTH-bit operands are captured in parallel on start. The 2*WIDTH-bit
// product is built over WIDTH iterations in an {C,ACC,Q} shift register.
// Optional feature macro: EARLY_DONE_EN. When it is defined, the block
// finishes early once the remaining multiplier bits are all zero.
module seq_mult_shift_add #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     out_acc_reg,
    output logic [WIDTH-1:0]     out_q_reg,
    output logic [1:0]           p_state
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   m_q,       m_d;
    logic [WIDTH-1:0]   acc_q,     acc_d;
    logic [WIDTH-1:0]   q_q,       q_d;
    logic               c_q,       c_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [PW-1:0]      product_q, product_d;
    logic               done_q,    done_d;
    logic               busy_q,    busy_d;

    logic [WIDTH:0]     sum_c;
    logic [PW:0]        shifted_c;
    logic               go_done_c;

`ifdef EARLY_DONE_EN
    logic [WIDTH-1:0]   low_mask_c;
    logic               early_c;
    logic [PW-1:0]      aligned_c;

    // Unconsumed multiplier bits and the single-step alignment shift
    always_comb begin
        low_mask_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            low_mask_c[i] = (CNT_W'(i) < cnt_q);
        end
        early_c   = ((q_q & low_mask_c) == '0);
        aligned_c = {acc_q, q_q} >> cnt_q;
    end
`endif

    // One add/shift iteration of the datapath, full carry kept
    always_comb begin
        sum_c     = {c_q, acc_q} + {1'b0, (q_q[0] ? m_q : {WIDTH{1'b0}})};
        shifted_c = {sum_c, q_q} >> 1;
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        go_done_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = a_in;
                    q_d     = b_in;
                    acc_d   = '0;
                    c_d     = 1'b0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                c_d   = shifted_c[PW];
                acc_d = shifted_c[PW-1:WIDTH];
                q_d   = shifted_c[WIDTH-1:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    go_done_c = 1'b1;
                end
`ifdef EARLY_DONE_EN
                if (early_c) begin
                    c_d       = 1'b0;
                    acc_d     = aligned_c[PW-1:WIDTH];
                    q_d       = aligned_c[WIDTH-1:0];
                    cnt_d     = '0;
                    go_done_c = 1'b1;
                end
`endif
                if (go_done_c) begin
                    state_d   = S_DONE;
                    product_d = {acc_d, q_d};
                    done_d    = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers, async active-low clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign product     = product_q;
    assign out_acc_reg = acc_q;
    assign out_q_reg   = q_q;
    assign p_state     = state_q;

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Directed self-checking bench for seq_mult_shift_add (WIDTH=8 and WIDTH=16).
module tb_seq_mult_shift_add;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        start;
    logic [7:0]  a_in, b_in;
    logic        busy, done;
    logic [15:0] product;
    logic [7:0]  acc_dbg, q_dbg;
    logic [1:0]  p_state;

    logic        start16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [31:0] product16;
    logic [15:0] acc16, q16;
    logic [1:0]  st16;

    int errors = 0;
    int checks = 0;

    seq_mult_shift_add #(.WIDTH(8)) u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .product(product),
        .out_acc_reg(acc_dbg), .out_q_reg(q_dbg), .p_state(p_state)
    );

    seq_mult_shift_add #(.WIDTH(16)) u_dut16 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .start(start16), .a_in(a16), .b_in(b16),
        .busy(busy16), .done(done16), .product(product16),
        .out_acc_reg(acc16), .out_q_reg(q16), .p_state(st16)
    );

    always #5 i_clk = ~i_clk;

    // Count one comparison and report it on mismatch
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycles from the start-sampling edge until done is observed
    function automatic int exp_lat(input int w, input logic [31:0] b);
        int hb;
        int early;
        hb = -1;
        for (int i = 0; i < w; i++) begin
            if (b[i]) hb = i;
        end
        early = (hb < 0) ? 1 : ((hb + 2 < w) ? hb + 2 : w);
`ifdef EARLY_DONE_EN
        return early;
`else
        return (early > 0) ? w : w;
`endif
    endfunction

    // One multiply; optionally pulse a second start while busy
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] expp, input bit inject);
        int lat;
        logic [15:0] prev;
        prev = product;
        @(negedge i_clk);
        start = 1'b1; a_in = a; b_in = b;
        @(posedge i_clk); #1;
        start = 1'b0; a_in = 8'hA5; b_in = 8'h5A;
        chk({tag, "_busy_e0"}, 64'(busy), 64'(1));
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (inject && k == 3) begin
                start = 1'b1; a_in = 8'd1; b_in = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge i_clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            if (k == 1) chk({tag, "_held"}, 64'(product), 64'(prev));
        end
        start = 1'b0;
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(8, 32'(b))));
        chk({tag, "_prod"}, 64'(product), 64'(expp));
        @(posedge i_clk); #1;
        chk({tag, "_busy_after"}, 64'(busy), 64'(0));
        chk({tag, "_done_after"}, 64'(done), 64'(0));
        chk({tag, "_prod_kept"}, 64'(product), 64'(expp));
    endtask

    initial begin
        int t, t1, t2, lat16;
        i_rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
        start16 = 1'b0; a16 = '0; b16 = '0;
        #12;
        chk("rst_busy",  64'(busy),    64'(0));
        chk("rst_done",  64'(done),    64'(0));
        chk("rst_prod",  64'(product), 64'(0));
        chk("rst_state", 64'(p_state), 64'(0));
        @(negedge i_clk);
        i_rst_n = 1'b1;

        run_op("m13x11",  8'd13,  8'd11,  16'h008F, 1'b0);
        run_op("m255x255", 8'd255, 8'd255, 16'hFE01, 1'b0);
        run_op("m0x200",  8'd0,   8'd200, 16'h0000, 1'b0);
        run_op("m200x1",  8'd200, 8'd1,   16'h00C8, 1'b0);
        run_op("m200x0",  8'd200, 8'd0,   16'h0000, 1'b0);
        run_op("m1x80",   8'd1,   8'h80,  16'h0080, 1'b0);
        run_op("ign",     8'd13,  8'd11,  16'h008F, 1'b1);

        // Held start: back-to-back operations
        @(negedge i_clk);
        start = 1'b1; a_in = 8'd13; b_in = 8'd11;
        t1 = -1; t2 = -1;
        for (t = 0; t < 60; t++) begin
            @(posedge i_clk); #1;
            if (done) begin
                if (t1 < 0) t1 = t;
                else begin
                    t2 = t;
                    break;
                end
            end
        end
        start = 1'b0;
        chk("b2b_gap",  64'(t2 - t1), 64'(exp_lat(8, 32'd11) + 2));
        chk("b2b_prod", 64'(product), 64'(16'h008F));
        repeat (2) @(posedge i_clk);

        // Reset in the 4th CALC cycle aborts with everything cleared
        @(negedge i_clk);
        start = 1'b1; a_in = 8'd13; b_in = 8'd11;
        @(posedge i_clk); #1;
        start = 1'b0;
        repeat (3) @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("abort_busy",  64'(busy),    64'(0));
        chk("abort_done",  64'(done),    64'(0));
        chk("abort_prod",  64'(product), 64'(0));
        chk("abort_state", 64'(p_state), 64'(0));
        chk("abort_acc",   64'(acc_dbg), 64'(0));
        chk("abort_q",     64'(q_dbg),   64'(0));
        repeat (2) @(posedge i_clk);
        #1;
        chk("abort_nodone", 64'(done), 64'(0));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run_op("m7x9", 8'd7, 8'd9, 16'h003F, 1'b0);

        // WIDTH=16 instance
        @(negedge i_clk);
        start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0003;
        @(posedge i_clk); #1;
        start16 = 1'b0; a16 = 16'h1234; b16 = 16'h4321;
        lat16 = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge i_clk); #1;
            if (done16) begin
                lat16 = k;
                break;
            end
        end
        chk("w16_lat",  64'(lat16),     64'(exp_lat(16, 32'h0003)));
        chk("w16_prod", 64'(product16), 64'(32'h0002FFFD));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
